// File: rtl/yutorina_bus_master_if_if.sv
// rtl/yutorina_bus_master_if_if.sv - shared-bus signal bundle between a bus master and the arbiter/slaves
interface yutorina_bus_master_if_if #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
);
  logic              bus_req_;
  logic              bus_grant_;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_as_;
  logic              bus_rw;
  logic [DATA_W-1:0] bus_wr_data;
  logic [DATA_W-1:0] bus_rd_data;
  logic              bus_rdy_;

  modport master (
    output bus_req_, bus_addr, bus_as_, bus_rw, bus_wr_data,
    input  bus_grant_, bus_rd_data, bus_rdy_
  );

  modport slave (
    input  bus_req_, bus_addr, bus_as_, bus_rw, bus_wr_data,
    output bus_grant_, bus_rd_data, bus_rdy_
  );
endinterface

// File: rtl/yutorina_bus_master_if.sv
// rtl/yutorina_bus_master_if.sv - per-master CPU-to-shared-bus interface; optional watchdog via YUTORINA_BUS_TIMEOUT_EN
module yutorina_bus_master_if #(
  parameter int ADDR_W         = 30,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req_en,
  input  logic              cpu_rw,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wr_data,
  input  logic              stall,
  input  logic              flush,
  output logic [DATA_W-1:0] cpu_rd_data,
  output logic              cpu_busy,
  output logic              cpu_bus_err,
  yutorina_bus_master_if_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    ACCESS = 2'd2,
    STALL  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              req_q, req_d;
  logic              as_q, as_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              lat_rw_q, lat_rw_d;
  logic [ADDR_W-1:0] lat_addr_q, lat_addr_d;
  logic [DATA_W-1:0] lat_wdata_q, lat_wdata_d;
  logic [DATA_W-1:0] rd_buf_q, rd_buf_d;
  logic              finish_access;

`ifdef YUTORINA_BUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  assign bus.bus_req_    = req_q;
  assign bus.bus_as_     = as_q;
  assign bus.bus_rw      = rw_q;
  assign bus.bus_addr    = addr_q;
  assign bus.bus_wr_data = wdata_q;

  // Next-state and next-value logic for the request/strobe/access sequence
  always_comb begin
    state_d       = state_q;
    req_d         = req_q;
    as_d          = 1'b1;
    rw_d          = rw_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    lat_rw_d      = lat_rw_q;
    lat_addr_d    = lat_addr_q;
    lat_wdata_d   = lat_wdata_q;
    rd_buf_d      = rd_buf_q;
    finish_access = 1'b0;
`ifdef YUTORINA_BUS_TIMEOUT_EN
    cnt_d         = cnt_q;
    err_d         = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (cpu_req_en && !flush) begin
          req_d       = 1'b0;
          lat_rw_d    = cpu_rw;
          lat_addr_d  = cpu_addr;
          lat_wdata_d = cpu_wr_data;
          state_d     = REQ;
        end
      end
      REQ: begin
        if (flush) begin
          req_d   = 1'b1;
          state_d = IDLE;
        end else if (!bus.bus_grant_) begin
          as_d    = 1'b0;
          rw_d    = lat_rw_q;
          addr_d  = lat_addr_q;
          wdata_d = lat_wdata_q;
`ifdef YUTORINA_BUS_TIMEOUT_EN
          cnt_d   = '0;
`endif
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (!bus.bus_rdy_) begin
          rd_buf_d      = bus.bus_rd_data;
          finish_access = 1'b1;
`ifdef YUTORINA_BUS_TIMEOUT_EN
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          rd_buf_d      = '0;
          err_d         = 1'b1;
          finish_access = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
        // Releasing the request here hands the bus back to the arbiter
        if (finish_access) begin
          req_d   = 1'b1;
          addr_d  = '0;
          rw_d    = 1'b1;
          wdata_d = '0;
          state_d = stall ? STALL : IDLE;
        end
      end
      STALL: begin
        if (!stall) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered state and bus outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      req_q       <= 1'b1;
      as_q        <= 1'b1;
      rw_q        <= 1'b1;
      addr_q      <= '0;
      wdata_q     <= '0;
      lat_rw_q    <= 1'b1;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      rd_buf_q    <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      as_q        <= as_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      lat_rw_q    <= lat_rw_d;
      lat_addr_q  <= lat_addr_d;
      lat_wdata_q <= lat_wdata_d;
      rd_buf_q    <= rd_buf_d;
    end
  end

`ifdef YUTORINA_BUS_TIMEOUT_EN
  // Watchdog counter and one-cycle error pulse
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign cpu_bus_err = err_q;
`else
  assign cpu_bus_err = 1'b0;
`endif

  // CPU-side stall and load-data return; live bus data is forwarded in the ready cycle
  always_comb begin
    cpu_busy    = 1'b0;
    cpu_rd_data = rd_buf_q;
    case (state_q)
      IDLE:    cpu_busy = cpu_req_en && !flush;
      REQ:     cpu_busy = 1'b1;
      ACCESS: begin
        cpu_busy = bus.bus_rdy_;
        if (!bus.bus_rdy_) cpu_rd_data = bus.bus_rd_data;
      end
      STALL:   cpu_busy = 1'b0;
      default: cpu_busy = 1'b0;
    endcase
  end

endmodule
